// File: rtl/sdram_axi_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_axi_arbiter
// Shares the single AXI4-Lite master port of the SDRAM controller between
// two single-word req/ack requesters: rq0 (instruction fetch) and rq1
// (data load/store). One transaction is outstanding at a time.
//
// Parameters
//   PRIO_MODE  0 = round-robin between rq0/rq1, 1 = fixed priority (rq0 wins)
//
// Ports
//   i_clk, i_rstn                  clock, asynchronous active-low reset
//   i_rqN_req/we/addr/wdata/wstrb  request (N=0,1); held until o_rqN_ack
//   o_rqN_ack                      one-cycle completion pulse
//   o_rqN_rdata, o_rqN_err         read data / resp[1], valid with ack
//   o_m_axi_ar*, i_m_axi_arready   read address channel
//   i_m_axi_r*, o_m_axi_rready     read data channel
//   o_m_axi_aw*, i_m_axi_awready   write address channel
//   o_m_axi_w*, i_m_axi_wready     write data channel
//   i_m_axi_b*, o_m_axi_bready     write response channel
//   o_busy                         high from grant until the ack cycle
// ---------------------------------------------------------------------------
module sdram_axi_arbiter #(
    parameter int PRIO_MODE = 0
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_rq0_req,
    input  logic        i_rq0_we,
    input  logic [31:0] i_rq0_addr,
    input  logic [31:0] i_rq0_wdata,
    input  logic [3:0]  i_rq0_wstrb,
    output logic        o_rq0_ack,
    output logic [31:0] o_rq0_rdata,
    output logic        o_rq0_err,
    input  logic        i_rq1_req,
    input  logic        i_rq1_we,
    input  logic [31:0] i_rq1_addr,
    input  logic [31:0] i_rq1_wdata,
    input  logic [3:0]  i_rq1_wstrb,
    output logic        o_rq1_ack,
    output logic [31:0] o_rq1_rdata,
    output logic        o_rq1_err,
    output logic [31:0] o_m_axi_araddr,
    output logic        o_m_axi_arvalid,
    input  logic        i_m_axi_arready,
    input  logic [31:0] i_m_axi_rdata,
    input  logic [1:0]  i_m_axi_rresp,
    input  logic        i_m_axi_rvalid,
    output logic        o_m_axi_rready,
    output logic [31:0] o_m_axi_awaddr,
    output logic        o_m_axi_awvalid,
    input  logic        i_m_axi_awready,
    output logic [31:0] o_m_axi_wdata,
    output logic [3:0]  o_m_axi_wstrb,
    output logic        o_m_axi_wvalid,
    input  logic        i_m_axi_wready,
    input  logic [1:0]  i_m_axi_bresp,
    input  logic        i_m_axi_bvalid,
    output logic        o_m_axi_bready,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WADDR = 3'd3,
        ST_WRESP = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_gnt, w_gnt_nxt;
    logic        r_rr_last, w_rr_last_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_arvalid, w_arvalid_nxt;
    logic [31:0] r_araddr, w_araddr_nxt;
    logic        r_rready, w_rready_nxt;
    logic        r_awvalid, w_awvalid_nxt;
    logic [31:0] r_awaddr, w_awaddr_nxt;
    logic        r_wvalid, w_wvalid_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [3:0]  r_wstrb, w_wstrb_nxt;
    logic        r_bready, w_bready_nxt;
    logic        r_rq0_ack, w_rq0_ack_nxt;
    logic [31:0] r_rq0_rdata, w_rq0_rdata_nxt;
    logic        r_rq0_err, w_rq0_err_nxt;
    logic        r_rq1_ack, w_rq1_ack_nxt;
    logic [31:0] r_rq1_rdata, w_rq1_rdata_nxt;
    logic        r_rq1_err, w_rq1_err_nxt;

    logic        w_win;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_sel_wstrb;
    logic        w_cpl;
    logic [31:0] w_cpl_rdata;
    logic        w_cpl_err;
    logic        w_aw_left;
    logic        w_w_left;
    // Only resp[1] distinguishes error responses; resp[0] is deliberately ignored.
    logic        w_unused_resp;

    assign w_unused_resp = i_m_axi_rresp[0] ^ i_m_axi_bresp[0];

    // Arbitration: pick the winner and mux its payload.
    always_comb begin
        w_win = 1'b0;
        if (i_rq0_req && i_rq1_req) begin
            // Tie: fixed priority favours rq0, round-robin favours the one not served last.
            w_win = (PRIO_MODE == 1) ? 1'b0 : ~r_rr_last;
        end else begin
            w_win = i_rq1_req;
        end
        w_sel_we    = w_win ? i_rq1_we    : i_rq0_we;
        w_sel_addr  = w_win ? i_rq1_addr  : i_rq0_addr;
        w_sel_wdata = w_win ? i_rq1_wdata : i_rq0_wdata;
        w_sel_wstrb = w_win ? i_rq1_wstrb : i_rq0_wstrb;
    end

    // Next-state and next-output logic of the transfer FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_rr_last_nxt   = r_rr_last;
        w_busy_nxt      = r_busy;
        w_arvalid_nxt   = r_arvalid;
        w_araddr_nxt    = r_araddr;
        w_rready_nxt    = r_rready;
        w_awvalid_nxt   = r_awvalid;
        w_awaddr_nxt    = r_awaddr;
        w_wvalid_nxt    = r_wvalid;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_bready_nxt    = r_bready;
        w_cpl           = 1'b0;
        w_cpl_rdata     = 32'd0;
        w_cpl_err       = 1'b0;
        w_aw_left       = r_awvalid & ~i_m_axi_awready;
        w_w_left        = r_wvalid & ~i_m_axi_wready;
        case (r_state)
            ST_IDLE: begin
                if (i_rq0_req || i_rq1_req) begin
                    w_gnt_nxt     = w_win;
                    w_rr_last_nxt = w_win;
                    w_busy_nxt    = 1'b1;
                    if (w_sel_we) begin
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                        w_awaddr_nxt  = w_sel_addr;
                        w_wdata_nxt   = w_sel_wdata;
                        w_wstrb_nxt   = w_sel_wstrb;
                        w_state_nxt   = ST_WADDR;
                    end else begin
                        w_arvalid_nxt = 1'b1;
                        w_araddr_nxt  = w_sel_addr;
                        w_state_nxt   = ST_RADDR;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RADDR: begin
                if (i_m_axi_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = ST_RDATA;
                end else begin
                    w_state_nxt = ST_RADDR;
                end
            end
            ST_RDATA: begin
                if (i_m_axi_rvalid) begin
                    w_rready_nxt = 1'b0;
                    w_cpl        = 1'b1;
                    w_cpl_rdata  = i_m_axi_rdata;
                    w_cpl_err    = i_m_axi_rresp[1];
                    w_state_nxt  = ST_DONE;
                end else begin
                    w_state_nxt = ST_RDATA;
                end
            end
            ST_WADDR: begin
                // AW and W are retired independently; the valid register
                // itself remembers which one is still pending.
                w_awvalid_nxt = w_aw_left;
                w_wvalid_nxt  = w_w_left;
                if (!w_aw_left && !w_w_left) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = ST_WRESP;
                end else begin
                    w_state_nxt = ST_WADDR;
                end
            end
            ST_WRESP: begin
                if (i_m_axi_bvalid) begin
                    w_bready_nxt = 1'b0;
                    w_cpl        = 1'b1;
                    w_cpl_rdata  = 32'd0;
                    w_cpl_err    = i_m_axi_bresp[1];
                    w_state_nxt  = ST_DONE;
                end else begin
                    w_state_nxt = ST_WRESP;
                end
            end
            ST_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_busy_nxt    = 1'b0;
                w_arvalid_nxt = 1'b0;
                w_rready_nxt  = 1'b0;
                w_awvalid_nxt = 1'b0;
                w_wvalid_nxt  = 1'b0;
                w_bready_nxt  = 1'b0;
                w_state_nxt   = ST_IDLE;
            end
        endcase
        // Completion is registered so ack lands in the DONE cycle; the
        // non-granted requester keeps its previous rdata/err.
        w_rq0_ack_nxt   = w_cpl & ~r_gnt;
        w_rq1_ack_nxt   = w_cpl & r_gnt;
        w_rq0_rdata_nxt = w_rq0_ack_nxt ? w_cpl_rdata : r_rq0_rdata;
        w_rq0_err_nxt   = w_rq0_ack_nxt ? w_cpl_err   : r_rq0_err;
        w_rq1_rdata_nxt = w_rq1_ack_nxt ? w_cpl_rdata : r_rq1_rdata;
        w_rq1_err_nxt   = w_rq1_ack_nxt ? w_cpl_err   : r_rq1_err;
    end

    // State and output registers; rr_last resets to 1 so rq0 wins the first tie.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= ST_IDLE;
            r_gnt       <= 1'b0;
            r_rr_last   <= 1'b1;
            r_busy      <= 1'b0;
            r_arvalid   <= 1'b0;
            r_araddr    <= 32'd0;
            r_rready    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_awaddr    <= 32'd0;
            r_wvalid    <= 1'b0;
            r_wdata     <= 32'd0;
            r_wstrb     <= 4'd0;
            r_bready    <= 1'b0;
            r_rq0_ack   <= 1'b0;
            r_rq0_rdata <= 32'd0;
            r_rq0_err   <= 1'b0;
            r_rq1_ack   <= 1'b0;
            r_rq1_rdata <= 32'd0;
            r_rq1_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_rr_last   <= w_rr_last_nxt;
            r_busy      <= w_busy_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_araddr    <= w_araddr_nxt;
            r_rready    <= w_rready_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_awaddr    <= w_awaddr_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_bready    <= w_bready_nxt;
            r_rq0_ack   <= w_rq0_ack_nxt;
            r_rq0_rdata <= w_rq0_rdata_nxt;
            r_rq0_err   <= w_rq0_err_nxt;
            r_rq1_ack   <= w_rq1_ack_nxt;
            r_rq1_rdata <= w_rq1_rdata_nxt;
            r_rq1_err   <= w_rq1_err_nxt;
        end
    end

    assign o_busy          = r_busy;
    assign o_m_axi_arvalid = r_arvalid;
    assign o_m_axi_araddr  = r_araddr;
    assign o_m_axi_rready  = r_rready;
    assign o_m_axi_awvalid = r_awvalid;
    assign o_m_axi_awaddr  = r_awaddr;
    assign o_m_axi_wvalid  = r_wvalid;
    assign o_m_axi_wdata   = r_wdata;
    assign o_m_axi_wstrb   = r_wstrb;
    assign o_m_axi_bready  = r_bready;
    assign o_rq0_ack       = r_rq0_ack;
    assign o_rq0_rdata     = r_rq0_rdata;
    assign o_rq0_err       = r_rq0_err;
    assign o_rq1_ack       = r_rq1_ack;
    assign o_rq1_rdata     = r_rq1_rdata;
    assign o_rq1_err       = r_rq1_err;

endmodule

// File: tb/tb_sdram_axi_arbiter.sv
module tb_sdram_axi_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = 32'd0, wdata0 = 32'd0, addr1 = 32'd0, wdata1 = 32'd0;
    logic [3:0]  wstrb0 = 4'd0, wstrb1 = 4'd0;
    logic        ack0, err0, ack1, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] araddr, awaddr, wdata;
    logic [3:0]  wstrb;
    logic        arvalid, rready, awvalid, wvalid, bready, busy;
    logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0] s_data = 32'd0;
    logic [1:0]  s_resp = 2'd0;
    int          ar_dly = 0, r_dly = 2, aw_dly = 0, w_dly = 0, b_dly = 2;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] m_rdata [2];
    logic        m_err [2];

    typedef struct {
        logic        rq;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  strb;
        int          ar_d, r_d, aw_d, w_d, b_d;
        logic [31:0] sdata;
        logic [1:0]  sresp;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_busy;
        int          exp_cyc_a;   // arvalid cycles (read) or awvalid cycles (write)
        int          exp_cyc_b;   // rready cycles (read) or wvalid cycles (write)
    } vec_t;

    vec_t vecs [6];
    vec_t vpost;

    sdram_axi_arbiter #(.PRIO_MODE(0)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_rq0_req(req0), .i_rq0_we(we0), .i_rq0_addr(addr0), .i_rq0_wdata(wdata0),
        .i_rq0_wstrb(wstrb0), .o_rq0_ack(ack0), .o_rq0_rdata(rdata0), .o_rq0_err(err0),
        .i_rq1_req(req1), .i_rq1_we(we1), .i_rq1_addr(addr1), .i_rq1_wdata(wdata1),
        .i_rq1_wstrb(wstrb1), .o_rq1_ack(ack1), .o_rq1_rdata(rdata1), .o_rq1_err(err1),
        .o_m_axi_araddr(araddr), .o_m_axi_arvalid(arvalid), .i_m_axi_arready(arready),
        .i_m_axi_rdata(s_data), .i_m_axi_rresp(s_resp), .i_m_axi_rvalid(rvalid),
        .o_m_axi_rready(rready),
        .o_m_axi_awaddr(awaddr), .o_m_axi_awvalid(awvalid), .i_m_axi_awready(awready),
        .o_m_axi_wdata(wdata), .o_m_axi_wstrb(wstrb), .o_m_axi_wvalid(wvalid),
        .i_m_axi_wready(wready),
        .i_m_axi_bresp(s_resp), .i_m_axi_bvalid(bvalid), .o_m_axi_bready(bready),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Slave model: readies/valids change on the falling edge after the programmed delay.
    always @(negedge clk) begin
        if (!rstn) begin
            arready = 1'b0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else begin
            if (arvalid) begin arready = (ar_cnt >= ar_dly); ar_cnt++; end
            else begin arready = 1'b0; ar_cnt = 0; end
            if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin awready = 1'b0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
            else begin wready = 1'b0; w_cnt = 0; end
            if (rready) begin r_cnt++; rvalid = (r_cnt >= r_dly); end
            else begin rvalid = 1'b0; r_cnt = 0; end
            if (bready) begin b_cnt++; bvalid = (b_cnt >= b_dly); end
            else begin bvalid = 1'b0; b_cnt = 0; end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int busy_cnt, ca, cb, ack_cnt, ar_issue, other_ack, bad_pay, bad_bready;
        logic prev_ar, done, timeout;
        logic [31:0] got_d;
        logic got_e;
        busy_cnt = 0; ca = 0; cb = 0; ack_cnt = 0; ar_issue = 0; other_ack = 0;
        bad_pay = 0; bad_bready = 0; prev_ar = 1'b0; done = 1'b0; timeout = 1'b1;
        got_d = 32'hFFFF_FFFF; got_e = 1'b0;
        ar_dly = v.ar_d; r_dly = v.r_d; aw_dly = v.aw_d; w_dly = v.w_d; b_dly = v.b_d;
        s_data = v.sdata; s_resp = v.sresp;
        if (v.rq) begin
            we1 = v.we; addr1 = v.addr; wdata1 = v.wd; wstrb1 = v.strb; req1 = 1'b1;
        end else begin
            we0 = v.we; addr0 = v.addr; wdata0 = v.wd; wstrb0 = v.strb; req0 = 1'b1;
        end
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (done) begin
                timeout = 1'b0;
                break;
            end
            if (busy) busy_cnt++;
            if (arvalid && !prev_ar) ar_issue++;
            prev_ar = arvalid;
            if (arvalid && araddr !== v.addr) bad_pay++;
            if (awvalid && awaddr !== v.addr) bad_pay++;
            if (wvalid && (wdata !== v.wd || wstrb !== v.strb)) bad_pay++;
            if (bready && (awvalid || wvalid)) bad_bready++;
            if (v.we) begin
                if (awvalid) ca++;
                if (wvalid) cb++;
            end else begin
                if (arvalid) ca++;
                if (rready) cb++;
            end
            if ((v.rq ? ack0 : ack1) === 1'b1) other_ack++;
            if ((v.rq ? ack1 : ack0) === 1'b1) begin
                ack_cnt++;
                got_d = v.rq ? rdata1 : rdata0;
                got_e = v.rq ? err1 : err0;
                done = 1'b1;
            end
        end
        // Request drops on the edge that sampled ack.
        req0 = 1'b0; req1 = 1'b0;
        chk({nm, "_timeout"}, {31'd0, timeout}, 32'd0);
        chk({nm, "_ack_count"}, ack_cnt, 32'd1);
        chk({nm, "_rdata"}, got_d, v.exp_rdata);
        chk({nm, "_err"}, {31'd0, got_e}, {31'd0, v.exp_err});
        chk({nm, "_busy_cycles"}, busy_cnt, v.exp_busy);
        chk({nm, v.we ? "_awvalid_cycles" : "_arvalid_cycles"}, ca, v.exp_cyc_a);
        chk({nm, v.we ? "_wvalid_cycles" : "_rready_cycles"}, cb, v.exp_cyc_b);
        chk({nm, "_ar_issued"}, ar_issue, v.we ? 32'd0 : 32'd1);
        chk({nm, "_other_ack"}, other_ack, 32'd0);
        chk({nm, "_payload"}, bad_pay, 32'd0);
        chk({nm, "_bready_early"}, bad_bready, 32'd0);
        chk({nm, "_other_rdata_hold"}, v.rq ? rdata0 : rdata1, m_rdata[v.rq ? 0 : 1]);
        chk({nm, "_other_err_hold"}, {31'd0, v.rq ? err0 : err1}, {31'd0, m_err[v.rq ? 0 : 1]});
        m_rdata[v.rq ? 1 : 0] = v.exp_rdata;
        m_err[v.rq ? 1 : 0] = v.exp_err;
    endtask

    initial begin
        int n;
        int order [4];
        logic [31:0] first_ar;
        logic saw_rready;
        int late_ack;

        //          rq    we    addr          wdata         strb  ar r aw w b  sdata         resp   exp_rdata     err  busy a b
        vecs[0] = '{1'b1, 1'b1, 32'h0100_0010, 32'h0000_BBBB, 4'hF, 0, 0, 0, 0, 2, 32'h1111_1111, 2'b00, 32'h0000_0000, 1'b0, 4, 1, 1};
        vecs[1] = '{1'b0, 1'b0, 32'h0100_0000, 32'h0000_0000, 4'h0, 0, 2, 0, 0, 0, 32'h0000_00AA, 2'b00, 32'h0000_00AA, 1'b0, 4, 1, 2};
        vecs[2] = '{1'b0, 1'b1, 32'h0100_0020, 32'hDEAD_BEEF, 4'h3, 0, 0, 2, 0, 2, 32'h2222_2222, 2'b10, 32'h0000_0000, 1'b1, 6, 3, 1};
        vecs[3] = '{1'b1, 1'b0, 32'h0100_0044, 32'h0000_0000, 4'h0, 0, 5, 0, 0, 0, 32'h1234_5678, 2'b11, 32'h1234_5678, 1'b1, 7, 1, 5};
        vecs[4] = '{1'b1, 1'b0, 32'h0100_0048, 32'h0000_0000, 4'h0, 1, 2, 0, 0, 0, 32'hCAFE_F00D, 2'b01, 32'hCAFE_F00D, 1'b0, 5, 2, 2};
        vecs[5] = '{1'b0, 1'b1, 32'h0100_004C, 32'h00C0_FFEE, 4'h8, 0, 0, 0, 3, 1, 32'h3333_3333, 2'b11, 32'h0000_0000, 1'b1, 6, 1, 4};
        vpost   = '{1'b1, 1'b0, 32'h0100_0080, 32'h0000_0000, 4'h0, 0, 2, 0, 0, 0, 32'h0F0F_0F0F, 2'b00, 32'h0F0F_0F0F, 1'b0, 4, 1, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {24'd0, arvalid, rready, awvalid, wvalid, bready, ack0, ack1, busy}, 32'd0);
        chk("reset_data", araddr | awaddr | wdata | rdata0 | rdata1 | {28'd0, wstrb}
                          | {30'd0, err0, err1}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        m_rdata[0] = 32'd0; m_rdata[1] = 32'd0; m_err[0] = 1'b0; m_err[1] = 1'b0;

        // Both requesters read in the same cycle and stay requesting: 0,1,0,1
        ar_dly = 0; r_dly = 2; s_data = 32'h0000_5A5A; s_resp = 2'b00;
        we0 = 1'b0; addr0 = 32'h0100_0100; we1 = 1'b0; addr1 = 32'h0100_0200;
        req0 = 1'b1; req1 = 1'b1;
        n = 0; first_ar = 32'd0;
        for (int i = 0; i < 100 && n < 4; i++) begin
            @(posedge clk); #1;
            if (arvalid && first_ar == 32'd0) first_ar = araddr;
            if (ack0 === 1'b1) begin if (n < 4) order[n] = 0; n++; end
            if (ack1 === 1'b1) begin if (n < 4) order[n] = 1; n++; end
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        chk("arb_ack_count", n, 32'd4);
        chk("arb_first_araddr", first_ar, 32'h0100_0100);
        chk("arb_order0", order[0], 32'd0);
        chk("arb_order1", order[1], 32'd1);
        chk("arb_order2", order[2], 32'd0);
        chk("arb_order3", order[3], 32'd1);
        @(posedge clk); #1;
        chk("arb_idle_busy", {31'd0, busy}, 32'd0);
        m_rdata[0] = 32'h0000_5A5A; m_rdata[1] = 32'h0000_5A5A;

        // Table-driven single transfers
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i));
            @(posedge clk); #1;
        end

        // Asynchronous reset while waiting in RDATA
        ar_dly = 0; r_dly = 20; s_data = 32'h7777_7777; s_resp = 2'b00;
        we0 = 1'b0; addr0 = 32'h0100_0300; req0 = 1'b1;
        saw_rready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rready) saw_rready = 1'b1;
        end
        chk("rst_in_rdata_state", {31'd0, saw_rready & rready}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_async_ctrl", {24'd0, arvalid, rready, awvalid, wvalid, bready, ack0, ack1, busy}, 32'd0);
        req0 = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        late_ack = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack0 || ack1 || busy) late_ack++;
        end
        chk("rst_no_ack_after", late_ack, 32'd0);
        m_rdata[0] = 32'd0; m_rdata[1] = 32'd0; m_err[0] = 1'b0; m_err[1] = 1'b0;
        run_txn(vpost, "post_reset_rq1_read");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
